// File: rtl/ctrlr_poll_pkg.sv
// Shared definitions for the controller poller: slot addresses, FSM encodings,
// button bit positions and the read-word packing helper.
package ctrlr_poll_pkg;

  localparam int DATAWIDTH = 16;

  localparam logic [15:0] STATE_CTRLR0 = 16'hFFF0;
  localparam logic [15:0] STATE_CTRLR1 = 16'hFFF1;
  localparam logic [15:0] STATE_CTRLR2 = 16'hFFF2;
  localparam logic [15:0] STATE_CTRLR3 = 16'hFFF3;

  typedef enum logic [2:0] {
    CP_IDLE   = 3'd0,
    CP_LATCH  = 3'd1,
    CP_BIT_LO = 3'd2,
    CP_BIT_HI = 3'd3,
    CP_COMMIT = 3'd4
  } cp_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [7:0] btn_t;

  function automatic logic [DATAWIDTH-1:0] read_word(input logic fresh, input btn_t btns);
    return {{(DATAWIDTH-9){1'b0}}, fresh, btns};
  endfunction

endpackage

// File: rtl/ctrlr_poll_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, on counter wrap.
module tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ctrlr_poll.sv
// Polls four NES-style pads over a shared latch/clock bus and serves the
// committed button words (plus a per-pad fresh flag) to the memory controller.
module ctrlr_poll
  import ctrlr_poll_pkg::*;
#(
  parameter int TICK_DIV   = 300,
  parameter int POLL_TICKS = 2700
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrlr_re,
  input  logic [1:0]           addr_ctrlr,
  output logic [DATAWIDTH-1:0] din_ctrlrs,
  output logic                 ctrl_latch,
  output logic                 ctrl_clk,
  input  logic [3:0]           ctrl_data
);

  localparam int ICW = $clog2(POLL_TICKS + 1);

  logic            w_tick;
  logic [3:0]      r_sync1, r_sync2;
  cp_state_e       r_state, w_state_nxt;
  logic [ICW-1:0]  r_idle_cnt;
  logic            r_latch_ph;
  logic [2:0]      r_bit_idx;
  logic [7:0][3:0] r_shift_t;   // indexed [bit][pad] so one sample writes all pads
  logic [3:0][7:0] w_scan;
  logic [3:0][7:0] r_btns;
  logic [3:0]      r_fresh;
  logic            r_ctrl_latch, r_ctrl_clk;
  logic            w_latch_nxt, w_clk_nxt;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ctrl_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CP_IDLE;
      r_ctrl_latch <= 1'b0;
      r_ctrl_clk   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ctrl_latch <= w_latch_nxt;
      r_ctrl_clk   <= w_clk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CP_IDLE:   if (w_tick && r_idle_cnt == ICW'(POLL_TICKS - 1)) w_state_nxt = CP_LATCH;
      CP_LATCH:  if (w_tick && r_latch_ph) w_state_nxt = CP_BIT_LO;
      CP_BIT_LO: if (w_tick) w_state_nxt = (r_bit_idx == 3'd7) ? CP_COMMIT : CP_BIT_HI;
      CP_BIT_HI: if (w_tick) w_state_nxt = CP_BIT_LO;
      CP_COMMIT: w_state_nxt = CP_IDLE;
      default:   w_state_nxt = CP_IDLE;
    endcase
  end

  // Bus levels decoded from the next state and registered, so they move only on tick edges.
  always_comb begin
    w_latch_nxt = (w_state_nxt == CP_LATCH);
    w_clk_nxt   = (w_state_nxt == CP_BIT_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_latch_ph <= 1'b0;
      r_bit_idx  <= '0;
      r_shift_t  <= '0;
    end else begin
      if (r_state != CP_IDLE) r_idle_cnt <= '0;
      else if (w_tick)        r_idle_cnt <= r_idle_cnt + 1'b1;

      if (r_state != CP_LATCH) r_latch_ph <= 1'b0;
      else if (w_tick)         r_latch_ph <= ~r_latch_ph;

      if (r_state == CP_LATCH)                r_bit_idx <= '0;
      else if (r_state == CP_BIT_HI && w_tick) r_bit_idx <= r_bit_idx + 1'b1;

      if (r_state == CP_BIT_LO && w_tick) r_shift_t[r_bit_idx] <= ~r_sync2;
    end
  end

  for (genvar p = 0; p < 4; p++) begin : g_pad
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign w_scan[p][b] = r_shift_t[b][p];
    end
  end

  // A commit in the same cycle as a read keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btns  <= '0;
      r_fresh <= '0;
    end else if (r_state == CP_COMMIT) begin
      r_btns  <= w_scan;
      r_fresh <= 4'hF;
    end else if (ctrlr_re) begin
      r_fresh[addr_ctrlr] <= 1'b0;
    end
  end

  assign din_ctrlrs = read_word(r_fresh[addr_ctrlr], r_btns[addr_ctrlr]);
  assign ctrl_latch = r_ctrl_latch;
  assign ctrl_clk   = r_ctrl_clk;

endmodule

// File: tb/tb_ctrlr_poll.sv
// Bench for ctrlr_poll: pad models on the serial bus, a button-level reference
// model, and a scoreboard checked whenever a read is presented.
module tb_ctrlr_poll;
  import ctrlr_poll_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrlr_re = 1'b0;
  logic [1:0]  addr_ctrlr = 2'd0;
  logic [15:0] din_ctrlrs;
  logic        ctrl_latch, ctrl_clk;
  logic [3:0]  ctrl_data = 4'hF;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  buttons[4];
  logic [7:0]  pad_latched[4];
  int          pad_idx = 0;
  bit          rand_btn_en = 1'b0;

  logic [7:0]  m_data[4];
  logic        m_fresh[4];
  logic [15:0] exp_q[$];

  ctrlr_poll #(.TICK_DIV(4), .POLL_TICKS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrlr_re   (ctrlr_re),
    .addr_ctrlr (addr_ctrlr),
    .din_ctrlrs (din_ctrlrs),
    .ctrl_latch (ctrl_latch),
    .ctrl_clk   (ctrl_clk),
    .ctrl_data  (ctrl_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: every presented read pops one expectation.
  always @(negedge clk) begin
    if (ctrlr_re) begin
      if (exp_q.size() == 0) check("sb_depth", exp_q.size(), 1);
      else check($sformatf("read_addr%0d", addr_ctrlr), din_ctrlrs, exp_q.pop_front());
    end
  end

  // Pad model: snapshot on latch, shift on clock rise, drive line after a random sub-clock delay.
  initial begin
    forever begin
      @(posedge ctrl_latch or posedge ctrl_clk);
      if (ctrl_latch) begin
        pad_latched = buttons;
        pad_idx = 0;
      end else begin
        pad_idx++;
      end
      for (int p = 0; p < 4; p++) begin
        #($urandom_range(1, 6));
        if (pad_idx < 8) ctrl_data[p] = ~pad_latched[p][pad_idx];
      end
    end
  end

  initial begin
    forever begin
      #($urandom_range(7, 53));
      if (rand_btn_en) buttons[$urandom_range(0, 3)] = 8'($urandom);
    end
  end

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_data[p]  = 8'h00;
      m_fresh[p] = 1'b0;
    end
  endtask

  task automatic do_read(input int a);
    @(posedge clk); #1;
    ctrlr_re   = 1'b1;
    addr_ctrlr = 2'(a);
    exp_q.push_back({7'b0, m_fresh[a], m_data[a]});
    m_fresh[a] = 1'b0;
    @(posedge clk); #1;
    ctrlr_re = 1'b0;
  endtask

  // Follows one scan on the bus; optionally checks its shape and collides a read with the commit.
  task automatic run_scan(input bit shape, input bit collide, input int caddr);
    int n, h;
    logic [7:0] snap[4];
    n = 0;
    while (!ctrl_latch && n < 400) begin @(negedge clk); n++; end
    if (shape) check_range("latch_rise_clk", n - 1, 36, 44);
    if (!ctrl_latch) begin
      check("latch_seen", ctrl_latch, 1);
      return;
    end
    snap = pad_latched;
    n = 0;
    while (ctrl_latch && n < 50) begin n++; @(negedge clk); end
    if (shape) check("latch_width", n, 8);
    for (int k = 0; k < 7; k++) begin
      n = 0;
      while (!ctrl_clk && n < 50) begin n++; @(negedge clk); end
      h = 0;
      while (ctrl_clk && h < 50) begin h++; @(negedge clk); end
      if (shape) begin
        check($sformatf("clk_lo_width%0d", k), n, 4);
        check($sformatf("clk_hi_width%0d", k), h, 4);
      end
    end
    // Last low phase runs one tick, then the COMMIT cycle.
    repeat (4) @(posedge clk);
    #1;
    if (collide) begin
      ctrlr_re   = 1'b1;
      addr_ctrlr = 2'(caddr);
      exp_q.push_back({7'b0, m_fresh[caddr], m_data[caddr]});
      @(posedge clk); #1;
      ctrlr_re = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    for (int p = 0; p < 4; p++) begin
      m_data[p]  = snap[p];
      m_fresh[p] = 1'b1;
    end
  endtask

  initial begin
    int k, n;
    logic prev;
    for (int p = 0; p < 4; p++) begin
      buttons[p]     = 8'h00;
      pad_latched[p] = 8'h00;
    end
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    for (int a = 0; a < 4; a++) do_read(a);
    check("reset_latch", ctrl_latch, 0);
    check("reset_clk", ctrl_clk, 0);
    buttons[0] = 8'((1 << BTN_A) | (1 << BTN_START));
    buttons[2] = 8'(1 << BTN_RIGHT);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // First scan shape and single-scan results
    run_scan(1'b1, 1'b0, 0);
    for (int a = 0; a < 4; a++) do_read(a);
    do_read(0);

    // Read colliding with commit
    buttons[1] = 8'(1 << BTN_B);
    run_scan(1'b0, 1'b1, 1);
    do_read(1);

    // Reset during the 4th clock pulse
    buttons[3] = 8'((1 << BTN_UP) | (1 << BTN_LEFT));
    n = 0;
    while (!ctrl_latch && n < 400) begin @(negedge clk); n++; end
    k = 0; n = 0; prev = 1'b0;
    while (k < 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (ctrl_clk && !prev) k++;
      prev = ctrl_clk;
    end
    check("pulse4_seen", k, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_clk", ctrl_clk, 0);
    check("abort_latch", ctrl_latch, 0);
    model_reset();
    for (int a = 0; a < 4; a++) do_read(a);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_scan(1'b1, 1'b0, 0);
    for (int a = 0; a < 4; a++) do_read(a);

    // Random buttons with asynchronous line changes
    rand_btn_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      run_scan(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      for (int r = 0; r < 5; r++) do_read(int'($urandom_range(0, 3)));
    end
    rand_btn_en = 1'b0;

    repeat (3) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
